memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Sits between the L1 caches (icache, dcache) and the single-ported RAM.
//  Arbitrates icache/dcache requests and forwards the granted request to RAM.
//  Returns load data and wait signals to the requester.
//  Holds dcache grant across its two-word block transfers (writeback/fill).
//  Guarantees icache forward progress with a starvation limit.
// PARAMETERS
//  STARVE_MAX  4   consecutive dcache grants while icache waits before icache is forced in
// PORTS
//  CLK       in   1   clock
//  nRST      in   1   reset, asynchronous, active-low
//  iREN      in   1   icache read request
//  iaddr     in   32  icache word address
//  iload     out  32  instruction word to icache
//  iwait     out  1   1 = icache must hold its request
//  dREN      in   1   dcache read request
//  dWEN      in   1   dcache write request
//  daddr     in   32  dcache word address
//  dstore    in   32  dcache write data
//  dload     out  32  load word to dcache
//  dwait     out  1   1 = dcache must hold its request
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   FREE=0 BUSY=1 ACCESS=2 ERROR=3
// BEHAVIOUR
//  - Request flags: dreq = dREN|dWEN; ireq = iREN.
//  - Registered FSM: ARB, DSERV, ISERV.
//    - beat (1b): dcache word count within a block.
//    - starve_cnt (width clog2(STARVE_MAX+1)).
//  - Reset: FSM=ARB, beat=0, starve_cnt=0.
//    - Outputs: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
//  - ARB: RAM enables 0, both waits 1.
//    - Next state, in priority order:
//      1. ireq && starve_cnt==STARVE_MAX -> ISERV
//      2. dreq -> DSERV
//      3. ireq -> ISERV
//      4. else stay in ARB.
//    - Latency: RAM is driven the cycle after the request is first seen in ARB.
//  - DSERV: ramaddr=daddr, ramstore=dstore.
//    - dWEN -> ramWEN=1, ramREN=0; dWEN wins if dREN and dWEN are both set.
//    - Otherwise ramREN=dREN.
//    - iwait=1.
//    - dwait=0 only in a cycle with ramstate==ACCESS; that cycle dload=ramload.
//    - On ACCESS:
//      - beat==0 -> beat=1, stay DSERV (second word keeps grant).
//      - beat==1 -> beat=0, go ARB.
//      - If ireq: starve_cnt += 1 (saturating at STARVE_MAX); otherwise starve_cnt=0.
//    - If dreq drops while in DSERV (no ACCESS) -> beat=0, go ARB; RAM enables 0 that cycle.
//  - ISERV: ramREN=1, ramaddr=iaddr, dwait=1.
//    - iwait=0 and iload=ramload only when ramstate==ACCESS.
//    - On ACCESS -> ARB, starve_cnt=0.
//    - If ireq drops -> ARB.
//  - ramstate BUSY or FREE: the requester keeps waiting; no timeout.
//  - ramstate ERROR: treated as wait; the request is held unchanged (retry).
//  - Waits are never 0 in ARB; iwait and dwait are never 0 in the same cycle.
//  - dload/iload are 0 when the matching wait is 1.
//  - Reset asserted mid-transfer: immediate return to reset values.
//    - A pending half block is abandoned; the caches must re-request.
// CONFIGURATION
//  MEMARB_STATS_EN defined: adds the following outputs, all reset to 0, wrap-around on overflow:
//    stat_dxfers  out 32  count of dcache ACCESS cycles
//    stat_ixfers  out 32  count of icache ACCESS cycles
//    stat_stalls  out 32  count of cycles with (ireq&&iwait)||(dreq&&dwait)
//  MEMARB_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. Reset with all inputs 0.
//     -> iwait=dwait=1, ramREN=ramWEN=0, FSM=ARB.
//  2. iREN=1, iaddr=0x40, ramstate ACCESS at the 2nd cycle after the request, ramload=0xDEADBEEF.
//     -> iwait=0 and iload=0xDEADBEEF for exactly one cycle.
//  3. dWEN=1, daddr=0x100 then 0x104, dstore=0x11 then 0x22, ACCESS each beat.
//     -> two ram writes with no ARB cycle between them; then ARB.
//  4. dREN and iREN together, RAM always ACCESS, dcache re-requesting continuously.
//     -> after STARVE_MAX dcache words, one icache grant; starve_cnt then 0.
//  5. dREN=1 with ramstate=ERROR for 3 cycles, then ACCESS.
//     -> dwait=1 for those 3 cycles, ramaddr stable; then dwait=0.
//  6. nRST low during DSERV beat 1.
//     -> outputs at reset values at once, beat=0.
//     -> With MEMARB_STATS_EN: counters read 0.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Cache/RAM bus seen by the arbiter; slave = arbiter side, master = caches plus RAM.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// icache/dcache -> single-port RAM arbiter; RAM driven 1 cycle after a request is seen, waits held until ACCESS.
// dcache keeps the grant for 2-word blocks, icache forced in after STARVE_MAX words; MEMARB_STATS_EN adds counters.
module memory_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    memory_arbiter_if.slave   bus
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0]       stat_dxfers,
    output logic [31:0]       stat_ixfers,
    output logic [31:0]       stat_stalls
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] DSERV = 2'd1;
    localparam logic [1:0] ISERV = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          beat, beat_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;

    logic dreq, ireq, ram_acc, d_acc, i_acc;

    assign dreq    = bus.dREN | bus.dWEN;
    assign ireq    = bus.iREN;
    assign ram_acc = (bus.ramstate == RAM_ACCESS);
    // A dropped request never completes, even if RAM reports ACCESS that cycle.
    assign d_acc   = (state == DSERV) && dreq && ram_acc;
    assign i_acc   = (state == ISERV) && ireq && ram_acc;

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = 32'h0;
        bus.dload    = 32'h0;
        case (state)
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = dreq & bus.dWEN;
                bus.ramREN   = dreq & bus.dREN & ~bus.dWEN;
                bus.dwait    = ~d_acc;
                bus.dload    = d_acc ? bus.ramload : 32'h0;
            end
            ISERV: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~i_acc;
                bus.iload   = i_acc ? bus.ramload : 32'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        starve_nxt = starve_cnt;
        case (state)
            ARB: begin
                if (ireq && starve_cnt == STARVE_LIM) state_nxt = ISERV;
                else if (dreq)                        state_nxt = DSERV;
                else if (ireq)                        state_nxt = ISERV;
            end
            DSERV: begin
                if (!dreq) begin
                    state_nxt = ARB;
                    beat_nxt  = 1'b0;
                end else if (d_acc) begin
                    if (ireq) starve_nxt = (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + SW'(1);
                    else      starve_nxt = '0;
                    if (beat) begin
                        beat_nxt  = 1'b0;
                        state_nxt = ARB;
                    end else begin
                        beat_nxt  = 1'b1;
                    end
                end
            end
            ISERV: begin
                if (!ireq) begin
                    state_nxt = ARB;
                end else if (i_acc) begin
                    state_nxt  = ARB;
                    starve_nxt = '0;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ARB;
            beat       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            starve_cnt <= starve_nxt;
        end
    end

`ifdef MEMARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_dxfers <= 32'h0;
            stat_ixfers <= 32'h0;
            stat_stalls <= 32'h0;
        end else begin
            if (d_acc) stat_dxfers <= stat_dxfers + 32'h1;
            if (i_acc) stat_ixfers <= stat_ixfers + 32'h1;
            if ((ireq && bus.iwait) || (dreq && bus.dwait)) stat_stalls <= stat_stalls + 32'h1;
        end
    end
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed scenarios plus randomized traffic checked every cycle against a bus-ownership model.
module tb_memory_arbiter;
    localparam int STARVE_MAX = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    memory_arbiter_if bus();

`ifdef MEMARB_STATS_EN
    logic [31:0] stat_dxfers, stat_ixfers, stat_stalls;
`endif

    memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .bus   (bus)
`ifdef MEMARB_STATS_EN
        ,
        .stat_dxfers (stat_dxfers),
        .stat_ixfers (stat_ixfers),
        .stat_stalls (stat_stalls)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: who owns the RAM (0 nobody, 1 dcache, 2 icache), words done in the
    // current dcache block, and dcache words served while icache waited.
    int m_owner, m_words, m_starve;
    int m_dx, m_ix, m_st;

    // Snapshot of the DUT outputs from the most recent check.
    logic        s_iwait, s_dwait, s_ramREN, s_ramWEN;
    logic [31:0] s_iload, s_dload, s_ramaddr;

    task automatic model_reset();
        m_owner = 0; m_words = 0; m_starve = 0;
        m_dx = 0; m_ix = 0; m_st = 0;
    endtask

    function automatic bit dreq_now();
        return bus.dREN | bus.dWEN;
    endfunction

    function automatic bit dacc_now();
        return m_owner == 1 && dreq_now() && bus.ramstate == 2'd2;
    endfunction

    function automatic bit iacc_now();
        return m_owner == 2 && bus.iREN && bus.ramstate == 2'd2;
    endfunction

    task automatic check_outs();
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
        e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
        if (m_owner == 1) begin
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
            e_dwait = !dacc_now();
            if (dacc_now()) e_dload = bus.ramload;
        end else if (m_owner == 2) begin
            e_ren   = 1;
            e_addr  = bus.iaddr;
            e_iwait = !iacc_now();
            if (iacc_now()) e_iload = bus.ramload;
        end
        chk("iwait",    32'(bus.iwait),  32'(e_iwait));
        chk("dwait",    32'(bus.dwait),  32'(e_dwait));
        chk("ramREN",   32'(bus.ramREN), 32'(e_ren));
        chk("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
        chk("ramaddr",  bus.ramaddr,  e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("iload",    bus.iload,    e_iload);
        chk("dload",    bus.dload,    e_dload);
`ifdef MEMARB_STATS_EN
        chk("stat_dxfers", stat_dxfers, 32'(m_dx));
        chk("stat_ixfers", stat_ixfers, 32'(m_ix));
        chk("stat_stalls", stat_stalls, 32'(m_st));
`endif
        s_iwait = bus.iwait; s_dwait = bus.dwait;
        s_ramREN = bus.ramREN; s_ramWEN = bus.ramWEN;
        s_iload = bus.iload; s_dload = bus.dload; s_ramaddr = bus.ramaddr;
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic model_step();
        bit dreq, ireq, dacc, iacc;
        dreq = dreq_now(); ireq = bus.iREN;
        dacc = dacc_now(); iacc = iacc_now();
        if (dacc) m_dx++;
        if (iacc) m_ix++;
        if ((ireq && !(iacc)) || (dreq && !(dacc))) m_st++;
        case (m_owner)
            0: begin
                if (ireq && m_starve == STARVE_MAX) m_owner = 2;
                else if (dreq) m_owner = 1;
                else if (ireq) m_owner = 2;
            end
            1: begin
                if (!dreq) begin
                    m_owner = 0; m_words = 0;
                end else if (dacc) begin
                    m_starve = ireq ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                    m_words++;
                    if (m_words == 2) begin
                        m_words = 0; m_owner = 0;
                    end
                end
            end
            default: begin
                if (!ireq) m_owner = 0;
                else if (iacc) begin
                    m_owner = 0; m_starve = 0;
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge CLK);
        check_outs();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic mid_reset();
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
    endtask

    initial begin
        int dw;
        bit got;
        idle_inputs();
        nRST = 1'b0;
        #2;
        model_reset();
        check_outs();
        chk("t1_iwait", 32'(s_iwait), 32'd1);
        chk("t1_dwait", 32'(s_dwait), 32'd1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // icache read, ACCESS two cycles after the request
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramload = 32'hDEADBEEF; bus.ramstate = 2'd0;
        dw = 0;
        cycle();
        if (!s_iwait) dw++;
        bus.ramstate = 2'd1;
        cycle();
        if (!s_iwait) dw++;
        bus.ramstate = 2'd2;
        cycle();
        if (!s_iwait) dw++;
        chk("t2_iload", s_iload, 32'hDEADBEEF);
        bus.iREN = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            if (!s_iwait) dw++;
        end
        chk("t2_iwait_low_cycles", 32'(dw), 32'd1);

        // dcache two-word writeback
        idle_inputs();
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'h11;
        cycle();
        bus.ramstate = 2'd2;
        cycle();
        chk("t3_w0_wen",  32'(s_ramWEN), 32'd1);
        chk("t3_w0_addr", s_ramaddr, 32'h100);
        bus.daddr = 32'h104; bus.dstore = 32'h22;
        cycle();
        chk("t3_w1_wen",  32'(s_ramWEN), 32'd1);
        chk("t3_w1_addr", s_ramaddr, 32'h104);
        bus.dWEN = 0;
        cycle();
        chk("t3_arb_wen", 32'(s_ramWEN), 32'd0);

        // starvation limit: both keep requesting, RAM always ready
        idle_inputs();
        bus.dREN = 1; bus.iREN = 1; bus.ramstate = 2'd2; bus.daddr = 32'h300; bus.iaddr = 32'h80;
        for (int pass = 0; pass < 2; pass++) begin
            dw = 0; got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                bus.ramload = $urandom;
                cycle();
                if (!s_dwait) dw++;
                if (!s_iwait) got = 1;
            end
            chk("t4_igrant_seen", 32'(got), 32'd1);
            chk("t4_dwords_before_igrant", 32'(dw), 32'(STARVE_MAX));
        end

        // RAM ERROR holds the dcache request
        idle_inputs();
        cycle();
        bus.dREN = 1; bus.daddr = 32'h200; bus.ramstate = 2'd3; bus.ramload = 32'h5A5A0001;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_err_dwait", 32'(s_dwait), 32'd1);
            chk("t5_err_addr",  s_ramaddr, 32'h200);
        end
        bus.ramstate = 2'd2;
        cycle();
        chk("t5_acc_dwait", 32'(s_dwait), 32'd0);
        chk("t5_acc_dload", s_dload, 32'h5A5A0001);

        // reset during the second beat
        bus.ramstate = 2'd1;
        cycle();
        mid_reset();
        chk("t6_ramREN", 32'(s_ramREN), 32'd0);
        chk("t6_dwait",  32'(s_dwait), 32'd1);
        bus.ramstate = 2'd2;
        for (int k = 0; k < 4; k++) cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            bus.iREN   = ($urandom_range(0, 3) != 0);
            bus.dREN   = ($urandom_range(0, 2) == 0);
            bus.dWEN   = ($urandom_range(0, 3) == 0);
            bus.iaddr  = $urandom;
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
            bus.ramload = $urandom;
            r = int'($urandom_range(0, 7));
            bus.ramstate = (r >= 4) ? 2'd2 : 2'(r);
            if ($urandom_range(0, 249) == 0) mid_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
